// File: rtl/bru_pkg.sv
// Shared types and constants for the branch resolve unit.
// Optional statistics counter is enabled with BRU_STATS_EN.
package bru_pkg;

   localparam int unsigned BRU_ADDR_W = 16;
   localparam int unsigned BRU_CNT_W  = 16;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } bru_state_e;

   // The pc field width is fixed here; the unit is instantiated with ADDR_W == BRU_ADDR_W.
   typedef struct packed {
      logic                  pred_taken;
      logic [BRU_ADDR_W-1:0] pc;
   } bru_entry_t;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Fetch/execute-facing signal bundle of the branch resolve unit.
// oMispredCnt exists only when BRU_STATS_EN is defined.
interface branch_resolve_unit_if #(
   parameter int unsigned ADDR_W = bru_pkg::BRU_ADDR_W
);

   logic              iPredValid;
   logic              iPredTaken;
   logic [ADDR_W-1:0] iPredPc;
   logic              iResValid;
   logic              iResTaken;
   logic [ADDR_W-1:0] iResTarget;
   logic              oBranchCmd;
   logic              oBranchTaken;
   logic              oFlush;
   logic [ADDR_W-1:0] oRedirectPc;
   logic              oFull;
   logic              oEmpty;
   logic              oProtoErr;
`ifdef BRU_STATS_EN
   logic [bru_pkg::BRU_CNT_W-1:0] oMispredCnt;
`endif

   modport master (
      output iPredValid, iPredTaken, iPredPc, iResValid, iResTaken, iResTarget,
      input  oBranchCmd, oBranchTaken, oFlush, oRedirectPc, oFull, oEmpty, oProtoErr
`ifdef BRU_STATS_EN
      , input oMispredCnt
`endif
   );

   modport slave (
      input  iPredValid, iPredTaken, iPredPc, iResValid, iResTaken, iResTarget,
      output oBranchCmd, oBranchTaken, oFlush, oRedirectPc, oFull, oEmpty, oProtoErr
`ifdef BRU_STATS_EN
      , output oMispredCnt
`endif
   );

endinterface

// File: rtl/bru_fifo.sv
// In-order queue of predicted branches with synchronous clear.
// Callers only push when there is room and only pop when non-empty.
module bru_fifo
   import bru_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   clear_i,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  bru_entry_t             wdata_i,
   output bru_entry_t             rdata_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   full_o,
   output logic                   empty_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   bru_entry_t       mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W:0]   count_q;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + (PTR_W+1)'(1);
            2'b01:   count_q <= count_q - (PTR_W+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; pointers and count alone decide which slots are valid.
   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/branch_resolve_unit.sv
// Compares resolved branches against their fetch-time predictions and issues flushes.
// Define BRU_STATS_EN to add the saturating mispredict counter oMispredCnt.
module branch_resolve_unit
   import bru_pkg::*;
#(
   parameter int unsigned ADDR_W = BRU_ADDR_W,
   parameter int unsigned DEPTH  = 4
) (
   input logic                  iClk,
   input logic                  iRst,
   branch_resolve_unit_if.slave bus
);

   bru_state_e                 state_q, state_d;
   bru_entry_t                 head, wentry;
   logic [$clog2(DEPTH):0]     count;
   logic                       full, empty;
   logic                       pop_ok, push_ok, mispred, err_set;
   logic                       cmd_q, taken_q, err_q;
   logic [ADDR_W-1:0]          redirect_q, redirect_d;

   bru_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i   (iClk),
      .rst_i   (iRst),
      .clear_i (mispred),
      .push_i  (push_ok),
      .pop_i   (pop_ok),
      .wdata_i (wentry),
      .rdata_o (head),
      .count_o (count),
      .full_o  (full),
      .empty_o (empty)
   );

   // NOTE: every signal gets a default first so no path through the block infers a latch.
   always_comb begin
      state_d    = state_q;
      redirect_d = redirect_q;
      pop_ok     = 1'b0;
      push_ok    = 1'b0;
      mispred    = 1'b0;
      err_set    = 1'b0;
      wentry     = '{pred_taken: bus.iPredTaken, pc: BRU_ADDR_W'(bus.iPredPc)};
      case (state_q)
         RUN: begin
            pop_ok  = bus.iResValid && (count != '0);
            mispred = pop_ok && (head.pred_taken != bus.iResTaken);
            push_ok = bus.iPredValid && !mispred && (!full || pop_ok);
            err_set = (bus.iResValid && empty) || (bus.iPredValid && full && !bus.iResValid);
            if (mispred) begin
               state_d    = FLUSH;
               redirect_d = bus.iResTaken ? bus.iResTarget : ADDR_W'(head.pc) + ADDR_W'(1);
            end
         end
         // Younger instructions are squashed: both request strobes are ignored here.
         FLUSH:   state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_q    <= RUN;
         cmd_q      <= 1'b0;
         taken_q    <= 1'b0;
         redirect_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cmd_q      <= pop_ok;
         if (pop_ok) taken_q <= bus.iResTaken;
         redirect_q <= redirect_d;
         err_q      <= err_q | err_set;
      end
   end

   assign bus.oBranchCmd   = cmd_q;
   assign bus.oBranchTaken = taken_q;
   assign bus.oFlush       = (state_q == FLUSH);
   assign bus.oRedirectPc  = redirect_q;
   assign bus.oFull        = full;
   assign bus.oEmpty       = empty;
   assign bus.oProtoErr    = err_q;

`ifdef BRU_STATS_EN
   logic [BRU_CNT_W-1:0] mispred_cnt_q;

   always_ff @(posedge iClk) begin
      if (iRst)                                mispred_cnt_q <= '0;
      else if (mispred && mispred_cnt_q != '1) mispred_cnt_q <= mispred_cnt_q + BRU_CNT_W'(1);
   end

   assign bus.oMispredCnt = mispred_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed and randomized checks of branch_resolve_unit against a queue-based reference model.
module tb_branch_resolve_unit;

   localparam int ADDR_W = 16;
   localparam int DEPTH  = 4;

   typedef struct {
      bit          t;
      logic [15:0] pc;
   } ent_t;

   logic iClk = 1'b0;
   logic iRst = 1'b1;

   branch_resolve_unit_if #(.ADDR_W(ADDR_W)) bus ();

   branch_resolve_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .iClk (iClk),
      .iRst (iRst),
      .bus  (bus)
   );

   always #5 iClk = ~iClk;

   int total = 0;
   int bad   = 0;

   ent_t        mq[$];
   bit          m_flush, m_cmd, m_taken, m_err;
   logic [15:0] m_redir;
   int          m_cnt;

   // Drives one cycle of inputs, advances the reference model at the edge, samples 1 time unit later.
   task automatic step(input bit rst, input bit pv, input bit pt, input logic [15:0] ppc,
                       input bit rv, input bit rt, input logic [15:0] tg);
      ent_t h;
      bit   nf;
      iRst           = rst;
      bus.iPredValid = pv;
      bus.iPredTaken = pt;
      bus.iPredPc    = ppc;
      bus.iResValid  = rv;
      bus.iResTaken  = rt;
      bus.iResTarget = tg;
      @(posedge iClk);
      nf = 1'b0;
      if (rst) begin
         mq.delete();
         m_flush = 0; m_cmd = 0; m_taken = 0; m_redir = '0; m_err = 0; m_cnt = 0;
      end else if (m_flush) begin
         m_flush = 0;
         m_cmd   = 0;
      end else begin
         m_cmd = 0;
         if (rv) begin
            if (mq.size() == 0) m_err = 1;
            else begin
               h       = mq.pop_front();
               m_cmd   = 1;
               m_taken = rt;
               if (h.t != rt) begin
                  nf      = 1;
                  m_redir = rt ? tg : 16'((int'(h.pc) + 1) % (1 << ADDR_W));
                  mq.delete();
                  if (m_cnt < 65535) m_cnt++;
               end
            end
         end
         if (pv && !nf) begin
            if (mq.size() < DEPTH) mq.push_back('{t: pt, pc: ppc});
            else m_err = 1;
         end
         m_flush = nf;
      end
      #1;
   endtask

   task automatic idle();
      step(0, 0, 0, '0, 0, 0, '0);
   endtask

   task automatic test_reset();
      step(1, 1, 1, 16'h1234, 1, 1, 16'h5678);
      step(1, 0, 0, '0, 0, 0, '0);
      total++; if (bus.oBranchCmd !== 1'b0) begin bad++; $display("FAIL reset_cmd: got %b want 0", bus.oBranchCmd); end
      total++; if (bus.oBranchTaken !== 1'b0) begin bad++; $display("FAIL reset_taken: got %b want 0", bus.oBranchTaken); end
      total++; if (bus.oFlush !== 1'b0) begin bad++; $display("FAIL reset_flush: got %b want 0", bus.oFlush); end
      total++; if (bus.oRedirectPc !== 16'h0) begin bad++; $display("FAIL reset_redir: got %h want 0000", bus.oRedirectPc); end
      total++; if (bus.oProtoErr !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", bus.oProtoErr); end
      total++; if (bus.oEmpty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b want 1", bus.oEmpty); end
      total++; if (bus.oFull !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", bus.oFull); end
`ifdef BRU_STATS_EN
      total++; if (bus.oMispredCnt !== 16'h0) begin bad++; $display("FAIL reset_cnt: got %h want 0000", bus.oMispredCnt); end
`endif
   endtask

   task automatic test_correct_pred();
      step(1, 0, 0, '0, 0, 0, '0);
      step(0, 1, 1, 16'h0010, 0, 0, '0);
      step(0, 0, 0, '0, 1, 1, 16'h0040);
      total++; if (bus.oBranchCmd !== 1'b1) begin bad++; $display("FAIL cp_cmd: got %b want 1", bus.oBranchCmd); end
      total++; if (bus.oBranchTaken !== 1'b1) begin bad++; $display("FAIL cp_taken: got %b want 1", bus.oBranchTaken); end
      total++; if (bus.oFlush !== 1'b0) begin bad++; $display("FAIL cp_flush: got %b want 0", bus.oFlush); end
      total++; if (bus.oRedirectPc !== 16'h0) begin bad++; $display("FAIL cp_redir_hold: got %h want 0000", bus.oRedirectPc); end
      idle();
      total++; if (bus.oBranchCmd !== 1'b0) begin bad++; $display("FAIL cp_cmd_pulse: got %b want 0", bus.oBranchCmd); end
   endtask

   task automatic test_mispredict();
      step(0, 1, 0, 16'h0020, 0, 0, '0);
      step(0, 0, 0, '0, 1, 1, 16'h0100);
      total++; if (bus.oFlush !== 1'b1) begin bad++; $display("FAIL mp_flush: got %b want 1", bus.oFlush); end
      total++; if (bus.oRedirectPc !== 16'h0100) begin bad++; $display("FAIL mp_redir: got %h want 0100", bus.oRedirectPc); end
      total++; if (bus.oEmpty !== 1'b1) begin bad++; $display("FAIL mp_empty: got %b want 1", bus.oEmpty); end
      step(0, 1, 1, 16'h0030, 0, 0, '0);
      total++; if (bus.oFlush !== 1'b0) begin bad++; $display("FAIL mp_flush_len: got %b want 0", bus.oFlush); end
      total++; if (bus.oEmpty !== 1'b1) begin bad++; $display("FAIL mp_push_ignored: empty got %b want 1", bus.oEmpty); end
      total++; if (bus.oRedirectPc !== 16'h0100) begin bad++; $display("FAIL mp_redir_hold: got %h want 0100", bus.oRedirectPc); end
   endtask

   task automatic test_wrap();
      step(0, 1, 1, 16'hFFFF, 0, 0, '0);
      step(0, 0, 0, '0, 1, 0, 16'h1234);
      total++; if (bus.oFlush !== 1'b1) begin bad++; $display("FAIL wrap_flush: got %b want 1", bus.oFlush); end
      total++; if (bus.oRedirectPc !== 16'h0000) begin bad++; $display("FAIL wrap_redir: got %h want 0000", bus.oRedirectPc); end
      total++; if (bus.oBranchTaken !== 1'b0) begin bad++; $display("FAIL wrap_taken: got %b want 0", bus.oBranchTaken); end
      idle();
   endtask

   task automatic test_full();
      step(1, 0, 0, '0, 0, 0, '0);
      for (int i = 0; i < DEPTH; i++) step(0, 1, 1, 16'(16'h0100 + i), 0, 0, '0);
      total++; if (bus.oFull !== 1'b1) begin bad++; $display("FAIL full_set: got %b want 1", bus.oFull); end
      total++; if (bus.oProtoErr !== 1'b0) begin bad++; $display("FAIL full_no_err: got %b want 0", bus.oProtoErr); end
      step(0, 1, 1, 16'h01FF, 0, 0, '0);
      total++; if (bus.oProtoErr !== 1'b1) begin bad++; $display("FAIL overflow_err: got %b want 1", bus.oProtoErr); end
      total++; if (bus.oFull !== 1'b1) begin bad++; $display("FAIL overflow_full: got %b want 1", bus.oFull); end
      step(0, 1, 1, 16'h0104, 1, 1, 16'h0200);
      total++; if (bus.oFull !== 1'b1) begin bad++; $display("FAIL pushpop_full: got %b want 1", bus.oFull); end
      total++; if (bus.oBranchCmd !== 1'b1) begin bad++; $display("FAIL pushpop_cmd: got %b want 1", bus.oBranchCmd); end
      // Head is now 0x0101; a not-taken resolve exposes its fall-through.
      step(0, 0, 0, '0, 1, 0, 16'h0300);
      total++; if (bus.oRedirectPc !== 16'h0102) begin bad++; $display("FAIL full_order: got %h want 0102", bus.oRedirectPc); end
      idle();
   endtask

   task automatic test_empty_pop();
      step(1, 0, 0, '0, 0, 0, '0);
      step(0, 0, 0, '0, 1, 1, 16'h0044);
      total++; if (bus.oBranchCmd !== 1'b0) begin bad++; $display("FAIL ep_cmd: got %b want 0", bus.oBranchCmd); end
      total++; if (bus.oProtoErr !== 1'b1) begin bad++; $display("FAIL ep_err: got %b want 1", bus.oProtoErr); end
      idle();
      total++; if (bus.oProtoErr !== 1'b1) begin bad++; $display("FAIL ep_sticky: got %b want 1", bus.oProtoErr); end
      step(1, 0, 0, '0, 0, 0, '0);
      total++; if (bus.oProtoErr !== 1'b0) begin bad++; $display("FAIL ep_rst_err: got %b want 0", bus.oProtoErr); end
      total++; if (bus.oEmpty !== 1'b1) begin bad++; $display("FAIL ep_rst_empty: got %b want 1", bus.oEmpty); end
      total++; if (bus.oRedirectPc !== 16'h0) begin bad++; $display("FAIL ep_rst_redir: got %h want 0000", bus.oRedirectPc); end
   endtask

   task automatic test_reset_mid_flush();
      step(1, 0, 0, '0, 0, 0, '0);
      step(0, 1, 0, 16'h0050, 0, 0, '0);
      step(0, 0, 0, '0, 1, 1, 16'h0060);
      total++; if (bus.oFlush !== 1'b1) begin bad++; $display("FAIL rmf_flush: got %b want 1", bus.oFlush); end
      step(1, 1, 1, 16'h0070, 1, 1, 16'h0080);
      total++; if (bus.oFlush !== 1'b0) begin bad++; $display("FAIL rmf_flush_clr: got %b want 0", bus.oFlush); end
      total++; if (bus.oRedirectPc !== 16'h0) begin bad++; $display("FAIL rmf_redir: got %h want 0000", bus.oRedirectPc); end
      total++; if (bus.oEmpty !== 1'b1) begin bad++; $display("FAIL rmf_empty: got %b want 1", bus.oEmpty); end
   endtask

`ifdef BRU_STATS_EN
   task automatic test_stats();
      step(1, 0, 0, '0, 0, 0, '0);
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 0, 16'(i), 0, 0, '0);
         step(0, 0, 0, '0, 1, 1, 16'h0900);
         idle();
      end
      for (int i = 0; i < 2; i++) begin
         step(0, 1, 1, 16'(i), 0, 0, '0);
         step(0, 0, 0, '0, 1, 1, 16'h0A00);
      end
      total++; if (bus.oMispredCnt !== 16'd3) begin bad++; $display("FAIL stats_cnt: got %0d want 3", bus.oMispredCnt); end
   endtask
`endif

   task automatic test_random();
      step(1, 0, 0, '0, 0, 0, '0);
      for (int n = 0; n < 600; n++) begin
         step(($urandom_range(0, 63) == 0), ($urandom_range(0, 99) < 55), $urandom_range(0, 1),
              16'($urandom), ($urandom_range(0, 99) < 45), $urandom_range(0, 1), 16'($urandom));
         total++; if (bus.oBranchCmd !== m_cmd) begin bad++; $display("FAIL rnd_cmd[%0d]: got %b want %b", n, bus.oBranchCmd, m_cmd); end
         total++; if (bus.oBranchTaken !== m_taken) begin bad++; $display("FAIL rnd_taken[%0d]: got %b want %b", n, bus.oBranchTaken, m_taken); end
         total++; if (bus.oFlush !== m_flush) begin bad++; $display("FAIL rnd_flush[%0d]: got %b want %b", n, bus.oFlush, m_flush); end
         total++; if (bus.oRedirectPc !== m_redir) begin bad++; $display("FAIL rnd_redir[%0d]: got %h want %h", n, bus.oRedirectPc, m_redir); end
         total++; if (bus.oProtoErr !== m_err) begin bad++; $display("FAIL rnd_err[%0d]: got %b want %b", n, bus.oProtoErr, m_err); end
         total++; if (bus.oFull !== (mq.size() == DEPTH)) begin bad++; $display("FAIL rnd_full[%0d]: got %b want %b", n, bus.oFull, (mq.size() == DEPTH)); end
         total++; if (bus.oEmpty !== (mq.size() == 0)) begin bad++; $display("FAIL rnd_empty[%0d]: got %b want %b", n, bus.oEmpty, (mq.size() == 0)); end
`ifdef BRU_STATS_EN
         total++; if (bus.oMispredCnt !== 16'(m_cnt)) begin bad++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", n, bus.oMispredCnt, m_cnt); end
`endif
      end
   endtask

   initial begin
      bus.iPredValid = 1'b0;
      bus.iPredTaken = 1'b0;
      bus.iPredPc    = '0;
      bus.iResValid  = 1'b0;
      bus.iResTaken  = 1'b0;
      bus.iResTarget = '0;
      test_reset();
      test_correct_pred();
      test_mispredict();
      test_wrap();
      test_full();
      test_empty_pop();
      test_reset_mid_flush();
`ifdef BRU_STATS_EN
      test_stats();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 Parameter ADDR_W, default 16, PC width in bits; instructions are word-addressed, so the fall-through PC is pc+1.
REQ-002 Parameter DEPTH, default 4, number of in-flight predicted branches; must be a power of two, minimum 2.
REQ-003 iClk  in  1  sole clock; all state updates on its rising edge.
REQ-004 iRst  in  1  reset, synchronous and active-high.
REQ-005 iPredValid  in  1  fetch issued a branch this cycle (push).
REQ-006 iPredTaken  in  1  direction predicted at fetch (the branch predictor's take output).
REQ-007 iPredPc  in  ADDR_W  PC of the predicted branch.
REQ-008 iResValid  in  1  execute resolved the oldest in-flight branch this cycle (pop).
REQ-009 iResTaken  in  1  actual direction.
REQ-010 iResTarget  in  ADDR_W  actual taken target.
REQ-011 oBranchCmd  out  1  predictor update strobe; drives the predictor's iBranchCmd.
REQ-012 oBranchTaken  out  1  actual direction for the update; drives the predictor's iBranchTaken.
REQ-013 oFlush  out  1  one-cycle mispredict flush to fetch and decode.
REQ-014 oRedirectPc  out  ADDR_W  corrected fetch PC, valid while oFlush=1.
REQ-015 oFull, oEmpty  out  1 each  in-flight queue status; fetch stalls branch issue while oFull=1.
REQ-016 oProtoErr  out  1  sticky protocol-violation flag.

Function
REQ-017 In-order queue of DEPTH entries {predTaken, pc}; push on iPredValid, pop on iResValid; the head is the oldest entry.
REQ-018 Outputs oBranchCmd, oBranchTaken, oFlush, oRedirectPc are registered and appear exactly 1 cycle after the iResValid cycle.
REQ-019 For a valid pop: oBranchCmd=1, oBranchTaken=iResTaken.
REQ-020 Mispredict = head.predTaken != iResTaken; on a mispredict, oFlush=1 and oRedirectPc = iResTaken ? iResTarget : head.pc+1, truncated to ADDR_W bits, wrapping at all-ones.
REQ-021 Correct prediction: oFlush=0 and oRedirectPc holds its previous value.
REQ-022 FSM states: RUN and FLUSH. Transition RUN->FLUSH on a mispredicting pop. FLUSH->RUN unconditionally after 1 cycle.
REQ-023 Mispredicting pop clears the whole queue at that edge; a push in the same cycle is discarded.
REQ-024 In FLUSH (the oFlush=1 cycle), iPredValid and iResValid are ignored, since younger instructions are being squashed.
REQ-025 Simultaneous push and non-mispredicting pop: both performed; occupancy is unchanged, and this is legal even when full.
REQ-026 Push while full without a pop: dropped and oProtoErr set.
REQ-027 Pop while empty: ignored, oBranchCmd stays 0, and oProtoErr is set.
REQ-028 oFull = (count==DEPTH) and oEmpty = (count==0), both from registered state; read/write pointers wrap modulo DEPTH.

Reset
REQ-029 iRst=1 at a rising edge clears the queue (count=0, pointers=0), sets FSM=RUN, and sets oBranchCmd=0, oBranchTaken=0, oFlush=0, oRedirectPc=0, oProtoErr=0, oEmpty=1, oFull=0.
REQ-030 Reset overrides any simultaneous push, pop or flush; reset mid-flush returns to RUN with oFlush=0 on the next cycle.

Configuration
REQ-031 Macro BRU_STATS_EN, when defined, adds output oMispredCnt (16 bits), which counts mispredicting pops, saturates at 16'hFFFF, and resets to 0.
REQ-032 When BRU_STATS_EN is undefined, the port and counter are absent and all other behaviour is identical.

Structure
REQ-033 Package bru_pkg holds the FSM state typedef (RUN, FLUSH), the queue-entry struct typedef and the counter width constant.
REQ-034 The queue is a sub-module bru_fifo (synchronous, with count, full/empty and clear input); the FSM and compare logic stay in branch_resolve_unit.

Verification
REQ-035 Reset, then push {taken=1, pc=0x0010}, then resolve taken with target 0x0040 -> next cycle oBranchCmd=1, oBranchTaken=1, oFlush=0.
REQ-036 Push {0, 0x0020}, then resolve taken with target 0x0100 -> oFlush=1, oRedirectPc=0x0100, queue empty, and a push on the following cycle is ignored.
REQ-037 Push {1, 0xFFFF}, then resolve not-taken -> oFlush=1 and oRedirectPc=0x0000 (wrap-around).
REQ-038 Fill 4 entries -> oFull=1; a 5th push sets oProtoErr=1 with count 4; simultaneous push and correct pop keeps oFull=1.
REQ-039 Pop while empty -> oBranchCmd=0 and oProtoErr=1; then assert iRst -> all outputs at reset values.
REQ-040 With BRU_STATS_EN defined, 3 mispredicts and 2 correct pops -> oMispredCnt=3.
